// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared widths, FSM encodings, ALU ctrl codes and operand helper for alu_arbiter
package alu_arb_pkg;

    localparam int DATA_W  = 32;
    localparam int CTRL_W  = 4;
    localparam int NUM_REQ = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MUL2 = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [CTRL_W-1:0] CTRL_AND = 4'd0;
    localparam logic [CTRL_W-1:0] CTRL_OR  = 4'd1;
    localparam logic [CTRL_W-1:0] CTRL_ADD = 4'd2;
    localparam logic [CTRL_W-1:0] CTRL_MUL = 4'd3;
    localparam logic [CTRL_W-1:0] CTRL_SUB = 4'd6;
    localparam logic [CTRL_W-1:0] CTRL_SLT = 4'd7;
    localparam logic [CTRL_W-1:0] CTRL_NOR = 4'd12;
    localparam logic [CTRL_W-1:0] CTRL_XOR = 4'd15;

    typedef struct packed {
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [CTRL_W-1:0] ctrl;
    } alu_op_t;

    // Pick one requester's slice out of the packed request buses.
    function automatic alu_op_t select_op(
        input logic                        id,
        input logic [NUM_REQ*DATA_W-1:0]   src1,
        input logic [NUM_REQ*DATA_W-1:0]   src2,
        input logic [NUM_REQ*CTRL_W-1:0]   ctrl
    );
        alu_op_t op;
        op.src1 = id ? src1[2*DATA_W-1:DATA_W] : src1[DATA_W-1:0];
        op.src2 = id ? src2[2*DATA_W-1:DATA_W] : src2[DATA_W-1:0];
        op.ctrl = id ? ctrl[2*CTRL_W-1:CTRL_W] : ctrl[CTRL_W-1:0];
        return op;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-winner pointer
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last_q holds the index of the most recent winner; reset to 1 so requester 0 wins first.
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters; ALU_ARB_MUL_STALL_EN adds a MUL2 stall cycle for multiply
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_src1_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_src2_i,
    input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl_i,
    output logic [DATA_W-1:0]         alu_src1_o,
    output logic [DATA_W-1:0]         alu_src2_o,
    output logic [CTRL_W-1:0]         alu_ctrl_o,
    input  logic [DATA_W-1:0]         alu_result_i,
    input  logic                      alu_zero_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic                      rsp_id_o,
    output logic [DATA_W-1:0]         rsp_result_o,
    output logic                      rsp_zero_o
);

    logic [1:0]        state_q;
    alu_op_t           op_q;
    logic              id_q;
    logic              rsp_id_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic              rsp_zero_q;
    logic [1:0]        grant;
    logic              arb_en;

    // Gating with rst_n keeps req_ready_o low while reset is held, even with requests pending.
    assign arb_en = (state_q == ST_IDLE) && rst_n;

    rr_arb2 u_rr_arb2 (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .en    (arb_en),
        .req   (req_valid_i),
        .gnt   (grant)
    );

    assign req_ready_o  = grant;
    assign alu_src1_o   = op_q.src1;
    assign alu_src2_o   = op_q.src2;
    assign alu_ctrl_o   = op_q.ctrl;
    assign rsp_valid_o  = (state_q == ST_RESP);
    assign rsp_id_o     = rsp_id_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_zero_o   = rsp_zero_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        op_q    <= select_op(grant[1], req_src1_i, req_src2_i, req_ctrl_i);
                        id_q    <= grant[1];
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
`ifdef ALU_ARB_MUL_STALL_EN
                    // Multiply gets an extra cycle; the result is taken in MUL2 instead.
                    if (op_q.ctrl == CTRL_MUL) begin
                        state_q <= ST_MUL2;
                    end else begin
                        rsp_id_q     <= id_q;
                        rsp_result_q <= alu_result_i;
                        rsp_zero_q   <= alu_zero_i;
                        state_q      <= ST_RESP;
                    end
`else
                    rsp_id_q     <= id_q;
                    rsp_result_q <= alu_result_i;
                    rsp_zero_q   <= alu_zero_i;
                    state_q      <= ST_RESP;
`endif
                end
`ifdef ALU_ARB_MUL_STALL_EN
                ST_MUL2: begin
                    rsp_id_q     <= id_q;
                    rsp_result_q <= alu_result_i;
                    rsp_zero_q   <= alu_zero_i;
                    state_q      <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
